// File: rtl/ifq_pkg.sv
//============================================================================
// Module      : ifq_pkg
// Description : Shared types and defaults for the instruction-fetch queue.
// Revision    : 1.0
//============================================================================
`default_nettype none

package ifq_pkg;

    localparam int              IFQ_BITS     = 32;
    localparam logic [IFQ_BITS-1:0] IFQ_RESET_PC = 32'h0;

    typedef struct packed {
        logic [IFQ_BITS-1:0] instr;
        logic [IFQ_BITS-1:0] pc;
    } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifq_if.sv
//============================================================================
// Module      : ifq_if
// Description : Fetch-queue bus: control, instruction memory and decode side.
// Revision    : 1.0
//============================================================================
`default_nettype none

interface ifq_if #(
    parameter int BITS     = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
);
    logic                fetch_en;
    logic                redirect;
    logic [BITS-1:0]     redirect_addr;
    logic                imem_req;
    logic [BITS-1:0]     imem_addr;
    logic [BITS-1:0]     imem_rdata;
    logic [BITS-1:0]     instr;
    logic [BITS-1:0]     instr_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic [PTR_BITS:0]   q_count;

    modport master (
        input  fetch_en, redirect, redirect_addr, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr, instr_pc, instr_valid, q_count
    );

    modport slave (
        output fetch_en, redirect, redirect_addr, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, q_count
    );
endinterface

`default_nettype wire

// File: rtl/ifq_fifo.sv
//============================================================================
// Module      : ifq_fifo
// Description : DEPTH-entry synchronous FIFO of ifq_entry_t with flush.
// Revision    : 1.0
//============================================================================
`default_nettype none

module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_flush,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  ifq_entry_t         i_wr_data,
    output ifq_entry_t         o_rd_data,
    output logic [PTR_BITS:0]  o_count,
    output logic               o_empty
);
    ifq_entry_t             r_mem [DEPTH];
    logic [PTR_BITS-1:0]    r_head;
    logic [PTR_BITS-1:0]    r_tail;
    logic [PTR_BITS:0]      r_count;
    logic                   w_full;

    assign w_full    = (r_count == (PTR_BITS+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && i_push) begin
            r_mem[r_tail] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PTR_BITS'(1);
            if (i_pop)  r_head <= r_head + PTR_BITS'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
//============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch with prefetch queue, credit-based issue and
//               redirect flush. Optional same-cycle bypass: IFQ_BYPASS_EN.
// Revision    : 1.0
//============================================================================
`default_nettype none

module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int              BITS     = IFQ_BITS,
    parameter int              DEPTH    = 4,
    parameter int              PTR_BITS = $clog2(DEPTH),
    parameter logic [BITS-1:0] RESET_PC = IFQ_RESET_PC
) (
    input  wire logic clk,
    input  wire logic rst,
    ifq_if.master     ifq
);
    logic [BITS-1:0]    r_fetch_pc;
    logic [BITS-1:0]    r_inflight_pc;
    logic               r_inflight;

    ifq_entry_t         w_rsp;
    ifq_entry_t         w_head;
    logic [PTR_BITS:0]  w_count;
    logic               w_empty;
    logic               w_byp;
    logic               w_valid;
    logic               w_pop;
    logic               w_fifo_pop;
    logic               w_push;
    logic               w_issue;
    logic [PTR_BITS+1:0] w_credit;

    assign w_rsp = '{instr: ifq.imem_rdata, pc: r_inflight_pc};

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_empty & r_inflight & ~ifq.redirect & ~rst;
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid    = (~w_empty | w_byp) & ~ifq.redirect & ~rst;
    assign w_pop      = w_valid & ifq.instr_ready;
    assign w_fifo_pop = w_pop & ~w_empty;
    // A bypassed word that decode takes immediately never enters the queue.
    assign w_push     = r_inflight & ~ifq.redirect & ~(w_byp & ifq.instr_ready);

    // Slots committed after this cycle; issue only if one is still free.
    assign w_credit = (PTR_BITS+2)'(w_count) + (PTR_BITS+2)'(r_inflight)
                    - (PTR_BITS+2)'(w_pop);
    assign w_issue  = ifq.fetch_en & ~ifq.redirect & ~rst
                    & (w_credit < (PTR_BITS+2)'(DEPTH));

    assign ifq.imem_req    = w_issue;
    assign ifq.imem_addr   = r_fetch_pc;
    assign ifq.instr_valid = w_valid;
    assign ifq.q_count     = w_count;

    always_comb begin
        ifq.instr    = '0;
        ifq.instr_pc = '0;
        if (w_byp) begin
            ifq.instr    = ifq.imem_rdata;
            ifq.instr_pc = r_inflight_pc;
        end else if (!w_empty && !rst) begin
            ifq.instr    = w_head.instr;
            ifq.instr_pc = w_head.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (ifq.redirect) begin
            r_fetch_pc    <= ifq.redirect_addr;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + BITS'(1);
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    ifq_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (ifq.redirect),
        .i_push    (w_push),
        .i_pop     (w_fifo_pop),
        .i_wr_data (w_rsp),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty)
    );

endmodule

`default_nettype wire
